sum_uart_tx: RTL

Downstream stage for the registered 8-bit adder result. It accepts each sum through a valid/ready handshake into a one-entry holding buffer. It then serialises the sum as an asynchronous UART frame on a single pin, formatted as start bit, data LSB-first, optional even parity, and stop bit. Back-to-back frames are sent with no idle gap when the buffer is refilled during transmission.

---
 rtl/sum_uart_tx.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sum_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : sum_uart_tx
// Purpose  : One-entry buffered UART transmitter for the adder sum (8N1 / 8E1)
// Revision : 1.0
// ============================================================================
module sum_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int c_baud_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_bit_w  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
  localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t              r_state;
  logic [c_baud_w-1:0] r_baud;
  logic [c_bit_w-1:0]  r_bit;
  logic [DATA_W-1:0]   r_shift;
  logic                r_parity;
  logic [DATA_W-1:0]   r_buf;
  logic                r_buf_full;
  logic                r_tx;
  logic                r_busy;
  logic                r_frame_done;

  state_t              w_state_nxt;
  logic [c_baud_w-1:0] w_baud_nxt;
  logic [c_bit_w-1:0]  w_bit_nxt;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic [DATA_W-1:0]   w_shift_sh;
  logic                w_parity_nxt;
  logic                w_tx_nxt;
  logic                w_load;
  logic                w_wrap;
  logic                w_hs;

  assign s_ready    = ~r_buf_full;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

  assign w_hs       = s_valid & ~r_buf_full;
  assign w_wrap     = (r_baud == c_baud_last);
  assign w_shift_sh = r_shift >> 1;

  always_comb begin
    w_state_nxt  = r_state;
    w_baud_nxt   = w_wrap ? '0 : r_baud + 1'b1;
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    w_tx_nxt     = r_tx;
    w_load       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_baud_nxt = '0;
        w_tx_nxt   = 1'b1;
        w_load     = r_buf_full;
      end
      ST_START: begin
        if (w_wrap) begin
          w_state_nxt = ST_DATA;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_wrap) begin
          if (r_bit == c_bit_last) begin
            w_state_nxt = PARITY_EN ? ST_PARITY : ST_STOP;
            w_tx_nxt    = PARITY_EN ? r_parity : 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 1'b1;
            w_shift_nxt = w_shift_sh;
            w_tx_nxt    = w_shift_sh[0];
          end
        end
      end
      ST_PARITY: begin
        if (w_wrap) begin
          w_state_nxt = ST_STOP;
          w_tx_nxt    = 1'b1;
        end
      end
      ST_STOP: begin
        if (w_wrap) begin
          // A full buffer chains straight into the next start bit.
          w_load      = r_buf_full;
          w_state_nxt = ST_IDLE;
          w_tx_nxt    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase

    if (w_load) begin
      w_state_nxt  = ST_START;
      w_baud_nxt   = '0;
      w_bit_nxt    = '0;
      w_shift_nxt  = r_buf;
      w_parity_nxt = ^r_buf;
      w_tx_nxt     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_baud       <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_baud       <= w_baud_nxt;
      r_bit        <= w_bit_nxt;
      r_shift      <= w_shift_nxt;
      r_parity     <= w_parity_nxt;
      r_tx         <= w_tx_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_frame_done <= (w_state_nxt == ST_STOP) && (w_baud_nxt == c_baud_last);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
    end else begin
      if (w_hs) begin
        r_buf <= s_data;
      end
      if (w_load) begin
        r_buf_full <= w_hs;
      end else if (w_hs) begin
        r_buf_full <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
